execute_stage: RTL and testbench

Parametrised execute stage for the RV32E core. It consumes decoded instructions over a valid/ready handshake and covers the full base ISA: ALU, branches, jumps, and loads/stores through a multi-cycle bus-master state machine. It drives register-file writeback and PC redirects to the control unit, and reports misaligned accesses. It sits between the decoder's skid buffer and the register file, control unit and data bus.

---
 rtl/execute_stage_if.sv | 47 ++++
 rtl/execute_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Signal bundle between the execute stage and its neighbours: decoder handshake,
// register-file writeback, PC redirect and the data-bus master port.
// Valid/ready: an instruction transfers on the rising edge where in_valid && in_ready;
// the producer holds in_* stable while in_valid is high and in_ready is low.
interface execute_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4,
    parameter int OP_W       = 6
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_op;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic [XLEN-1:0]       in_pc;
    logic                  flush;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]       rf_wdata;
    logic                  set_pc;
    logic [XLEN-1:0]       new_pc;
    logic                  misaligned;
    logic                  bus_req;
    logic                  bus_we;
    logic [XLEN-1:0]       bus_addr;
    logic [XLEN-1:0]       bus_wdata;
    logic [XLEN/8-1:0]     bus_wstrb;
    logic                  bus_ack;
    logic [XLEN-1:0]       bus_rdata;
    logic [1:0]            dbg_state;

    modport master (
        output in_valid, in_op, in_rd, in_rs1_data, in_rs2_data, in_imm, in_pc, flush,
               bus_ack, bus_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, set_pc, new_pc, misaligned,
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, dbg_state
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1_data, in_rs2_data, in_imm, in_pc, flush,
               bus_ack, bus_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, set_pc, new_pc, misaligned,
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, dbg_state
    );
endinterface

// File: rtl/execute_stage.sv
// RV32E execute stage: single-cycle ALU/branch/jump in IDLE, loads and stores
// through a MEM/DRAIN bus-master sequence, registered writeback and redirect.
module execute_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4,
    parameter int OP_W       = 6
) (
    input logic           clock,
    input logic           reset,
    execute_stage_if.slave io
);
    localparam int SH_W   = $clog2(XLEN);
    localparam int STRB_W = XLEN / 8;
    localparam int LANE_W = $clog2(STRB_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MEM   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [OP_W-1:0] INST_LUI   = OP_W'(1),  INST_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] INST_JAL   = OP_W'(3),  INST_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] INST_BEQ   = OP_W'(5),  INST_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] INST_BLT   = OP_W'(7),  INST_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] INST_BLTU  = OP_W'(9),  INST_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] INST_LB    = OP_W'(11), INST_LH    = OP_W'(12);
    localparam logic [OP_W-1:0] INST_LW    = OP_W'(13), INST_LBU   = OP_W'(14);
    localparam logic [OP_W-1:0] INST_LHU   = OP_W'(15), INST_SB    = OP_W'(16);
    localparam logic [OP_W-1:0] INST_SH    = OP_W'(17), INST_SW    = OP_W'(18);
    localparam logic [OP_W-1:0] INST_ADD   = OP_W'(19), INST_SUB   = OP_W'(20);
    localparam logic [OP_W-1:0] INST_SLL   = OP_W'(21), INST_SLT   = OP_W'(22);
    localparam logic [OP_W-1:0] INST_SLTU  = OP_W'(23), INST_XOR   = OP_W'(24);
    localparam logic [OP_W-1:0] INST_SRL   = OP_W'(25), INST_SRA   = OP_W'(26);
    localparam logic [OP_W-1:0] INST_OR    = OP_W'(27), INST_AND   = OP_W'(28);
    localparam logic [OP_W-1:0] INST_ADDI  = OP_W'(29), INST_SLTI  = OP_W'(30);
    localparam logic [OP_W-1:0] INST_SLTIU = OP_W'(31), INST_XORI  = OP_W'(32);
    localparam logic [OP_W-1:0] INST_ORI   = OP_W'(33), INST_ANDI  = OP_W'(34);
    localparam logic [OP_W-1:0] INST_SLLI  = OP_W'(35), INST_SRLI  = OP_W'(36);
    localparam logic [OP_W-1:0] INST_SRAI  = OP_W'(37);

    logic [1:0]            state_q, state_d;
    logic                  rf_we_q, rf_we_d, set_pc_q, set_pc_d, misaligned_q, misaligned_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d, ld_rd_q, ld_rd_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d, new_pc_q, new_pc_d;
    logic                  bus_req_q, bus_req_d, bus_we_q, bus_we_d, ld_uns_q, ld_uns_d;
    logic [XLEN-1:0]       bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [STRB_W-1:0]     bus_wstrb_q, bus_wstrb_d;
    logic [1:0]            ld_size_q, ld_size_d;

    logic [XLEN-1:0]   a, alu_b, ea, wr_data, pc_tgt, st_data, ld_shift, ld_data;
    logic [SH_W-1:0]   shamt;
    logic [LANE_W-1:0] lane;
    logic [STRB_W-1:0] strb;
    logic [1:0]        mem_size;
    logic              wr_en, pc_set, is_mem, mem_we, mem_uns, mis;

    // Instruction decode and single-cycle datapath.
    always_comb begin
        a        = io.in_rs1_data;
        ea       = io.in_rs1_data + io.in_imm;
        lane     = ea[LANE_W-1:0];
        wr_en    = 1'b0;
        wr_data  = '0;
        pc_set   = 1'b0;
        pc_tgt   = io.in_pc + io.in_imm;
        is_mem   = 1'b0;
        mem_we   = 1'b0;
        mem_uns  = 1'b0;
        mem_size = 2'd0;
        mis      = 1'b0;
        case (io.in_op)
            INST_ADDI, INST_SLTI, INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI,
            INST_SLLI, INST_SRLI, INST_SRAI: alu_b = io.in_imm;
            default:                         alu_b = io.in_rs2_data;
        endcase
        shamt = alu_b[SH_W-1:0];
        case (io.in_op)
            INST_ADD, INST_ADDI:   begin wr_en = 1'b1; wr_data = a + alu_b; end
            INST_SUB:              begin wr_en = 1'b1; wr_data = a - alu_b; end
            INST_SLL, INST_SLLI:   begin wr_en = 1'b1; wr_data = a << shamt; end
            INST_SLT, INST_SLTI:   begin wr_en = 1'b1; wr_data = XLEN'($signed(a) < $signed(alu_b)); end
            INST_SLTU, INST_SLTIU: begin wr_en = 1'b1; wr_data = XLEN'(a < alu_b); end
            INST_XOR, INST_XORI:   begin wr_en = 1'b1; wr_data = a ^ alu_b; end
            INST_SRL, INST_SRLI:   begin wr_en = 1'b1; wr_data = a >> shamt; end
            INST_SRA, INST_SRAI:   begin wr_en = 1'b1; wr_data = XLEN'($signed(a) >>> shamt); end
            INST_OR, INST_ORI:     begin wr_en = 1'b1; wr_data = a | alu_b; end
            INST_AND, INST_ANDI:   begin wr_en = 1'b1; wr_data = a & alu_b; end
            INST_LUI:              begin wr_en = 1'b1; wr_data = io.in_imm; end
            INST_AUIPC:            begin wr_en = 1'b1; wr_data = io.in_pc + io.in_imm; end
            INST_JAL:              begin wr_en = 1'b1; wr_data = io.in_pc + XLEN'(4); pc_set = 1'b1; end
            INST_JALR: begin
                wr_en   = 1'b1;
                wr_data = io.in_pc + XLEN'(4);
                pc_set  = 1'b1;
                pc_tgt  = {ea[XLEN-1:1], 1'b0};
            end
            INST_BEQ:  pc_set = (a == alu_b);
            INST_BNE:  pc_set = (a != alu_b);
            INST_BLT:  pc_set = ($signed(a) < $signed(alu_b));
            INST_BGE:  pc_set = ($signed(a) >= $signed(alu_b));
            INST_BLTU: pc_set = (a < alu_b);
            INST_BGEU: pc_set = (a >= alu_b);
            INST_LB, INST_LBU, INST_SB: begin
                is_mem  = 1'b1;
                mem_we  = (io.in_op == INST_SB);
                mem_uns = (io.in_op == INST_LBU);
            end
            INST_LH, INST_LHU, INST_SH: begin
                is_mem   = 1'b1;
                mem_size = 2'd1;
                mem_we   = (io.in_op == INST_SH);
                mem_uns  = (io.in_op == INST_LHU);
                mis      = ea[0];
            end
            INST_LW, INST_SW: begin
                is_mem   = 1'b1;
                mem_size = 2'd2;
                mem_we   = (io.in_op == INST_SW);
                mis      = |ea[1:0];
            end
            default: ;
        endcase
        // Narrow stores replicate the datum across every lane; the strobe picks one.
        case (mem_size)
            2'd0:    begin strb = STRB_W'(1) << lane;  st_data = {(XLEN/8){io.in_rs2_data[7:0]}}; end
            2'd1:    begin strb = STRB_W'(3) << lane;  st_data = {(XLEN/16){io.in_rs2_data[15:0]}}; end
            default: begin strb = STRB_W'(15) << lane; st_data = {(XLEN/32){io.in_rs2_data[31:0]}}; end
        endcase
    end

    // Load lane extraction, driven from the address held during the bus phase.
    always_comb begin
        ld_shift = io.bus_rdata >> {bus_addr_q[LANE_W-1:0], 3'b000};
        case (ld_size_q)
            2'd0: if (ld_uns_q) ld_data = XLEN'(ld_shift[7:0]);
                  else          ld_data = XLEN'($signed(ld_shift[7:0]));
            2'd1: if (ld_uns_q) ld_data = XLEN'(ld_shift[15:0]);
                  else          ld_data = XLEN'($signed(ld_shift[15:0]));
            default:            ld_data = XLEN'($signed(ld_shift[31:0]));
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        set_pc_d     = 1'b0;
        new_pc_d     = new_pc_q;
        misaligned_d = 1'b0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        ld_rd_d      = ld_rd_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;
        case (state_q)
            S_IDLE: if (io.in_valid && !io.flush) begin
                if (is_mem && mis) begin
                    misaligned_d = 1'b1;
                end else if (is_mem) begin
                    state_d     = S_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = ea;
                    bus_wdata_d = mem_we ? st_data : '0;
                    bus_wstrb_d = strb;
                    ld_rd_d     = io.in_rd;
                    ld_size_d   = mem_size;
                    ld_uns_d    = mem_uns;
                end else begin
                    if (wr_en && io.in_rd != '0) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = io.in_rd;
                        rf_wdata_d = wr_data;
                    end
                    if (pc_set) begin
                        set_pc_d = 1'b1;
                        new_pc_d = pc_tgt;
                    end
                end
            end
            // A flush coinciding with the ack still wins: the data is discarded.
            S_MEM: if (io.bus_ack) begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
                if (!io.flush && !bus_we_q && ld_rd_q != '0) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = ld_rd_q;
                    rf_wdata_d = ld_data;
                end
            end else if (io.flush) begin
                state_d = S_DRAIN;
            end
            S_DRAIN: if (io.bus_ack) begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            set_pc_q     <= 1'b0;
            new_pc_q     <= '0;
            misaligned_q <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            ld_rd_q      <= '0;
            ld_size_q    <= 2'd0;
            ld_uns_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            set_pc_q     <= set_pc_d;
            new_pc_q     <= new_pc_d;
            misaligned_q <= misaligned_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            ld_rd_q      <= ld_rd_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
        end
    end

    assign io.in_ready   = (state_q == S_IDLE);
    assign io.rf_we      = rf_we_q;
    assign io.rf_waddr   = rf_waddr_q;
    assign io.rf_wdata   = rf_wdata_q;
    assign io.set_pc     = set_pc_q;
    assign io.new_pc     = new_pc_q;
    assign io.misaligned = misaligned_q;
    assign io.bus_req    = bus_req_q;
    assign io.bus_we     = bus_we_q;
    assign io.bus_addr   = bus_addr_q;
    assign io.bus_wdata  = bus_wdata_q;
    assign io.bus_wstrb  = bus_wstrb_q;
    assign io.dbg_state  = state_q;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: 32-bit instance driven through a scoreboard of expected
// writebacks/redirects/misaligned pulses, plus a 64-bit instance for wide-lane loads.
module tb_execute_stage;
    localparam logic [5:0] INST_LUI = 6'd1,  INST_AUIPC = 6'd2, INST_JAL = 6'd3, INST_JALR = 6'd4;
    localparam logic [5:0] INST_BEQ = 6'd5,  INST_BNE = 6'd6,   INST_BLT = 6'd7, INST_BLTU = 6'd9;
    localparam logic [5:0] INST_LB  = 6'd11, INST_LH  = 6'd12,  INST_LW  = 6'd13, INST_LBU = 6'd14;
    localparam logic [5:0] INST_SB  = 6'd16, INST_SH  = 6'd17,  INST_SW  = 6'd18;
    localparam logic [5:0] INST_ADD = 6'd19, INST_SUB = 6'd20,  INST_SLL = 6'd21, INST_SLT = 6'd22;
    localparam logic [5:0] INST_SLTU = 6'd23, INST_XOR = 6'd24, INST_SRL = 6'd25, INST_SRA = 6'd26;
    localparam logic [5:0] INST_OR  = 6'd27, INST_AND = 6'd28,  INST_ADDI = 6'd29;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   busy_cnt = 0;

    logic [3:0]  exp_waddr_q[$];
    logic [31:0] exp_wdata_q[$];
    logic [31:0] exp_pc_q[$];
    logic        exp_mis_q[$];
    logic [63:0] exp64_q[$];

    always #5 clock = ~clock;

    execute_stage_if #(.XLEN(32), .REG_ADDR_W(4), .OP_W(6)) ifc32 ();
    execute_stage_if #(.XLEN(64), .REG_ADDR_W(4), .OP_W(6)) ifc64 ();

    execute_stage #(.XLEN(32), .REG_ADDR_W(4), .OP_W(6)) dut32 (.clock(clock), .reset(reset), .io(ifc32));
    execute_stage #(.XLEN(64), .REG_ADDR_W(4), .OP_W(6)) dut64 (.clock(clock), .reset(reset), .io(ifc64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            INST_ADD:  return x + y;
            INST_SUB:  return x - y;
            INST_SLL:  return x << y[4:0];
            INST_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            INST_SLTU: return (x < y) ? 32'd1 : 32'd0;
            INST_XOR:  return x ^ y;
            INST_SRL:  return x >> y[4:0];
            INST_SRA:  return $signed(x) >>> y[4:0];
            INST_OR:   return x | y;
            INST_AND:  return x & y;
            default:   return 32'd0;
        endcase
    endfunction

    // Scoreboard side: every observed pulse must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (ifc32.in_ready !== 1'b1) busy_cnt++;
            if (ifc32.rf_we) begin
                if (exp_waddr_q.size() == 0) check("rf_we_unexpected", 64'(ifc32.rf_we), 64'd0);
                else begin
                    check("rf_waddr", 64'(ifc32.rf_waddr), 64'(exp_waddr_q.pop_front()));
                    check("rf_wdata", 64'(ifc32.rf_wdata), 64'(exp_wdata_q.pop_front()));
                end
            end
            if (ifc32.set_pc) begin
                if (exp_pc_q.size() == 0) check("set_pc_unexpected", 64'(ifc32.set_pc), 64'd0);
                else check("new_pc", 64'(ifc32.new_pc), 64'(exp_pc_q.pop_front()));
            end
            if (ifc32.misaligned) begin
                if (exp_mis_q.size() == 0) check("mis_unexpected", 64'(ifc32.misaligned), 64'd0);
                else check("misaligned", 64'(ifc32.misaligned), 64'(exp_mis_q.pop_front()));
            end
            if (ifc64.rf_we) begin
                if (exp64_q.size() == 0) check("rf_we64_unexpected", 64'(ifc64.rf_we), 64'd0);
                else check("rf_wdata64", ifc64.rf_wdata, exp64_q.pop_front());
            end
        end
    end

    task automatic expect_wr(input logic [3:0] rd, input logic [31:0] data);
        exp_waddr_q.push_back(rd);
        exp_wdata_q.push_back(data);
    endtask

    // Called #1 after a rising edge; returns #1 after the transfer edge.
    task automatic issue(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc);
        int n;
        n = 0;
        while (ifc32.in_ready !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n == 50) check("issue_timeout", 64'(ifc32.in_ready), 64'd1);
        ifc32.in_valid = 1'b1;
        ifc32.in_op = op;
        ifc32.in_rd = rd;
        ifc32.in_rs1_data = rs1;
        ifc32.in_rs2_data = rs2;
        ifc32.in_imm = imm;
        ifc32.in_pc = pc;
        @(posedge clock); #1;
        ifc32.in_valid = 1'b0;
    endtask

    task automatic mem_txn(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] rs2, input int wait_n,
                           input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata);
        issue(op, rd, rs1, rs2, imm, 32'h0);
        check("bus_req", 64'(ifc32.bus_req), 64'd1);
        check("bus_addr", 64'(ifc32.bus_addr), 64'(rs1 + imm));
        check("bus_we", 64'(ifc32.bus_we), 64'(exp_we));
        check("bus_wstrb", 64'(ifc32.bus_wstrb), 64'(exp_strb));
        if (exp_we) check("bus_wdata", 64'(ifc32.bus_wdata), 64'(exp_wdata));
        repeat (wait_n) begin
            @(posedge clock); #1;
        end
        check("bus_addr_held", 64'(ifc32.bus_addr), 64'(rs1 + imm));
        check("bus_req_held", 64'(ifc32.bus_req), 64'd1);
        ifc32.bus_ack = 1'b1;
        ifc32.bus_rdata = rdata;
        @(posedge clock); #1;
        ifc32.bus_ack = 1'b0;
        ifc32.bus_rdata = 32'h0;
        check("bus_req_drop", 64'(ifc32.bus_req), 64'd0);
        check("ready_back", 64'(ifc32.in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  alu_ops[10];
        logic [5:0]  op;
        logic [31:0] x, y;
        logic [3:0]  rd;
        int          b0;
        alu_ops = '{INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU,
                    INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND};
        ifc32.in_valid = 1'b0; ifc32.in_op = '0; ifc32.in_rd = '0; ifc32.in_rs1_data = '0;
        ifc32.in_rs2_data = '0; ifc32.in_imm = '0; ifc32.in_pc = '0; ifc32.flush = 1'b0;
        ifc32.bus_ack = 1'b0; ifc32.bus_rdata = '0;
        ifc64.in_valid = 1'b0; ifc64.in_op = '0; ifc64.in_rd = '0; ifc64.in_rs1_data = '0;
        ifc64.in_rs2_data = '0; ifc64.in_imm = '0; ifc64.in_pc = '0; ifc64.flush = 1'b0;
        ifc64.bus_ack = 1'b0; ifc64.bus_rdata = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 64'(ifc32.in_ready), 64'd1);
        check("rst_rf_we", 64'(ifc32.rf_we), 64'd0);
        check("rst_rf_waddr", 64'(ifc32.rf_waddr), 64'd0);
        check("rst_rf_wdata", 64'(ifc32.rf_wdata), 64'd0);
        check("rst_set_pc", 64'(ifc32.set_pc), 64'd0);
        check("rst_new_pc", 64'(ifc32.new_pc), 64'd0);
        check("rst_misaligned", 64'(ifc32.misaligned), 64'd0);
        check("rst_bus_req", 64'(ifc32.bus_req), 64'd0);
        check("rst_bus_we", 64'(ifc32.bus_we), 64'd0);
        check("rst_bus_addr", 64'(ifc32.bus_addr), 64'd0);
        check("rst_bus_wdata", 64'(ifc32.bus_wdata), 64'd0);
        check("rst_bus_wstrb", 64'(ifc32.bus_wstrb), 64'd0);
        reset = 1'b0;

        // ALU, immediates, x0 suppression, flush in IDLE
        expect_wr(4'd5, 32'h8000_0000);
        issue(INST_ADD, 4'd5, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h0);
        expect_wr(4'd6, 32'hC000_0000);
        issue(INST_SRA, 4'd6, 32'h8000_0000, 32'd33, 32'd0, 32'h0);
        expect_wr(4'd7, 32'd7);
        issue(INST_ADDI, 4'd7, 32'd10, 32'd0, 32'hFFFF_FFFD, 32'h0);
        issue(INST_ADD, 4'd0, 32'd1, 32'd2, 32'd0, 32'h0);
        ifc32.flush = 1'b1;
        issue(INST_ADD, 4'd8, 32'd1, 32'd2, 32'd0, 32'h0);
        ifc32.flush = 1'b0;
        expect_wr(4'd2, 32'h1234_5000);
        issue(INST_LUI, 4'd2, 32'd0, 32'd0, 32'h1234_5000, 32'h0);
        expect_wr(4'd3, 32'h3000);
        issue(INST_AUIPC, 4'd3, 32'd0, 32'd0, 32'h2000, 32'h1000);

        // branches and jumps
        exp_pc_q.push_back(32'hF8);
        issue(INST_BEQ, 4'd9, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100);
        issue(INST_BNE, 4'd9, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100);
        exp_pc_q.push_back(32'h210);
        issue(INST_BLT, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200);
        issue(INST_BLTU, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200);
        exp_pc_q.push_back(32'h200);
        expect_wr(4'd1, 32'h304);
        issue(INST_JALR, 4'd1, 32'h201, 32'd0, 32'd0, 32'h300);
        exp_pc_q.push_back(32'h420);
        issue(INST_JAL, 4'd0, 32'd0, 32'd0, 32'h20, 32'h400);

        for (int i = 0; i < 16; i++) begin
            op = alu_ops[$urandom_range(0, 9)];
            rd = 4'($urandom_range(1, 15));
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            expect_wr(rd, model_alu(op, x, y));
            issue(op, rd, x, y, 32'd0, 32'h0);
        end

        // loads and stores
        expect_wr(4'd9, 32'hFFFF_FF80);
        b0 = busy_cnt;
        mem_txn(INST_LB, 4'd9, 32'h1000, 32'd3, 32'd0, 3, 32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0);
        check("lb_busy_cycles", 64'(busy_cnt - b0), 64'd4);
        expect_wr(4'd10, 32'h0000_0080);
        mem_txn(INST_LBU, 4'd10, 32'h1000, 32'd3, 32'd0, 1, 32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0);
        expect_wr(4'd11, 32'hFFFF_BEEF);
        mem_txn(INST_LH, 4'd11, 32'h1000, 32'd2, 32'd0, 0, 32'hBEEF_0000, 1'b0, 4'b1100, 32'h0);
        expect_wr(4'd12, 32'hDEAD_BEEF);
        mem_txn(INST_LW, 4'd12, 32'h1000, 32'd4, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0);
        mem_txn(INST_SH, 4'd0, 32'h1000, 32'd2, 32'hABCD_1234, 1, 32'h0, 1'b1, 4'b1100, 32'h1234_1234);
        mem_txn(INST_SB, 4'd0, 32'h1000, 32'd1, 32'h0000_005A, 0, 32'h0, 1'b1, 4'b0010, 32'h5A5A_5A5A);
        mem_txn(INST_SW, 4'd0, 32'h1000, 32'd0, 32'hCAFE_F00D, 2, 32'h0, 1'b1, 4'b1111, 32'hCAFE_F00D);

        exp_mis_q.push_back(1'b1);
        issue(INST_LW, 4'd13, 32'h1000, 32'd0, 32'd2, 32'h0);
        check("mis_lw_no_req", 64'(ifc32.bus_req), 64'd0);
        check("mis_lw_ready", 64'(ifc32.in_ready), 64'd1);
        exp_mis_q.push_back(1'b1);
        issue(INST_SH, 4'd0, 32'h1000, 32'h55, 32'd1, 32'h0);
        check("mis_sh_no_req", 64'(ifc32.bus_req), 64'd0);

        // flush one cycle into the bus phase, ack two cycles after that
        issue(INST_LW, 4'd14, 32'h2000, 32'd0, 32'd0, 32'h0);
        check("fl_req", 64'(ifc32.bus_req), 64'd1);
        @(posedge clock); #1;
        ifc32.flush = 1'b1;
        @(posedge clock); #1;
        ifc32.flush = 1'b0;
        check("fl_req_held", 64'(ifc32.bus_req), 64'd1);
        check("fl_not_ready", 64'(ifc32.in_ready), 64'd0);
        @(posedge clock); #1;
        check("fl_req_held2", 64'(ifc32.bus_req), 64'd1);
        ifc32.bus_ack = 1'b1;
        ifc32.bus_rdata = 32'h1111_1111;
        @(posedge clock); #1;
        ifc32.bus_ack = 1'b0;
        check("fl_req_drop", 64'(ifc32.bus_req), 64'd0);
        check("fl_ready", 64'(ifc32.in_ready), 64'd1);

        // reset in the middle of a bus transaction
        issue(INST_SW, 4'd0, 32'h3000, 32'h7777_7777, 32'd0, 32'h0);
        check("rm_req", 64'(ifc32.bus_req), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rm_bus_req", 64'(ifc32.bus_req), 64'd0);
        check("rm_in_ready", 64'(ifc32.in_ready), 64'd1);
        check("rm_bus_addr", 64'(ifc32.bus_addr), 64'd0);
        check("rm_bus_wdata", 64'(ifc32.bus_wdata), 64'd0);
        check("rm_rf_wdata", 64'(ifc32.rf_wdata), 64'd0);
        check("rm_new_pc", 64'(ifc32.new_pc), 64'd0);
        reset = 1'b0;

        // 64-bit build: word load from the upper lane
        ifc64.in_valid = 1'b1;
        ifc64.in_op = INST_LW;
        ifc64.in_rd = 4'd3;
        ifc64.in_rs1_data = 64'd0;
        ifc64.in_imm = 64'd4;
        @(posedge clock); #1;
        ifc64.in_valid = 1'b0;
        check("x64_bus_req", 64'(ifc64.bus_req), 64'd1);
        check("x64_bus_addr", ifc64.bus_addr, 64'd4);
        check("x64_bus_wstrb", 64'(ifc64.bus_wstrb), 64'hF0);
        exp64_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        ifc64.bus_ack = 1'b1;
        ifc64.bus_rdata = 64'hFFFF_FFFF_0000_0000;
        @(posedge clock); #1;
        ifc64.bus_ack = 1'b0;
        check("x64_ready", 64'(ifc64.in_ready), 64'd1);

        repeat (4) @(posedge clock);
        #1;
        check("sb_wr_left", 64'(exp_waddr_q.size()), 64'd0);
        check("sb_pc_left", 64'(exp_pc_q.size()), 64'd0);
        check("sb_mis_left", 64'(exp_mis_q.size()), 64'd0);
        check("sb_x64_left", 64'(exp64_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
